// File: rtl/alu_err_logger.sv
// Scoreboard stage behind the ALU tester's comparator: counts vectors and
// errors over one run, captures the first failing vector, reports pass/fail.
module alu_err_logger #(
    parameter int NUM_VECTORS = 16,
    parameter int CNT_W       = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             valid,
    input  logic [7:0]       err_in,
    input  logic [14:0]      result_alu,
    input  logic [14:0]      res_exp,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [14:0]      first_fail_got,
    output logic [14:0]      first_fail_exp,
    output logic             sticky_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(NUM_VECTORS - 1);
    localparam logic [CNT_W-1:0] LP_MAX  = '1;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_vec;
    logic [CNT_W-1:0] r_err;
    logic [CNT_W-1:0] r_ff_idx;
    logic [14:0]      r_ff_got;
    logic [14:0]      r_ff_exp;
    logic             r_sticky;
    logic             r_pass;

    logic             w_start_ok;
    logic             w_accept;
    logic             w_mismatch;
    logic             w_last;
    logic [CNT_W-1:0] w_err_next;

    assign w_start_ok = start && (r_state != S_RUN);
    assign w_accept   = valid && (r_state == S_RUN);
    assign w_mismatch = |err_in;
    assign w_last     = w_accept && (r_vec == LP_LAST);

    // Error counter saturates instead of wrapping.
    assign w_err_next = (w_accept && w_mismatch && (r_err != LP_MAX))
                      ? r_err + 1'b1 : r_err;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  if (start) w_next = S_RUN;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_vec    <= '0;
            r_err    <= '0;
            r_ff_idx <= '0;
            r_ff_got <= '0;
            r_ff_exp <= '0;
            r_sticky <= 1'b0;
            r_pass   <= 1'b0;
        end else if (w_start_ok) begin
            r_vec    <= '0;
            r_err    <= '0;
            r_ff_idx <= '0;
            r_ff_got <= '0;
            r_ff_exp <= '0;
            r_sticky <= 1'b0;
            r_pass   <= 1'b0;
        end else if (w_accept) begin
            r_vec <= r_vec + 1'b1;
            r_err <= w_err_next;
            if (w_mismatch && !r_sticky) begin
                r_ff_idx <= r_vec;
                r_ff_got <= result_alu;
                r_ff_exp <= res_exp;
                r_sticky <= 1'b1;
            end
            if (w_last) begin
                r_pass <= (w_err_next == '0);
            end
        end
    end

    always_comb begin
        busy = (r_state == S_RUN);
        done = (r_state == S_DONE);
    end

    assign pass           = r_pass;
    assign vec_count      = r_vec;
    assign err_count      = r_err;
    assign first_fail_idx = r_ff_idx;
    assign first_fail_got = r_ff_got;
    assign first_fail_exp = r_ff_exp;
    assign sticky_err     = r_sticky;

endmodule

// File: tb/tb_alu_err_logger.sv
// Randomised bench for alu_err_logger: two instances (8-bit/16-vector and
// 4-bit/15-vector) checked every cycle against a run-level reference model.
module tb_alu_err_logger;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        valid = 1'b0;
    logic [7:0]  err_in = 8'h00;
    logic [14:0] result_alu = '0;
    logic [14:0] res_exp = '0;

    logic        a_busy, a_done, a_pass, a_sticky;
    logic [7:0]  a_vec, a_err, a_idx;
    logic [14:0] a_got, a_exp;
    logic        b_busy, b_done, b_pass, b_sticky;
    logic [3:0]  b_vec, b_err, b_idx;
    logic [14:0] b_got, b_exp;

    always #5 clock = ~clock;

    alu_err_logger #(.NUM_VECTORS(16), .CNT_W(8)) dut_a (
        .clock(clock), .reset_n(reset_n), .start(start), .valid(valid),
        .err_in(err_in), .result_alu(result_alu), .res_exp(res_exp),
        .busy(a_busy), .done(a_done), .pass(a_pass), .vec_count(a_vec),
        .err_count(a_err), .first_fail_idx(a_idx),
        .first_fail_got(a_got), .first_fail_exp(a_exp),
        .sticky_err(a_sticky)
    );

    alu_err_logger #(.NUM_VECTORS(15), .CNT_W(4)) dut_b (
        .clock(clock), .reset_n(reset_n), .start(start), .valid(valid),
        .err_in(err_in), .result_alu(result_alu), .res_exp(res_exp),
        .busy(b_busy), .done(b_done), .pass(b_pass), .vec_count(b_vec),
        .err_count(b_err), .first_fail_idx(b_idx),
        .first_fail_got(b_got), .first_fail_exp(b_exp),
        .sticky_err(b_sticky)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s at %0t: got %h expected %h",
                         nm, $time, act, exp);
        end
    endtask

    // Reference model: run-level view (mode, samples seen, raw error tally,
    // index of first failing sample), per instance k.
    localparam int NV[2]  = '{16, 15};
    localparam int MAXE[2] = '{255, 15};
    int          m_mode[2];
    int          m_n[2];
    int          m_errs[2];
    int          m_ff[2];
    logic [14:0] m_got[2];
    logic [14:0] m_exp[2];
    bit          m_pass[2];

    always @(posedge clock) begin
        if (!reset_n) chk_en <= 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (!reset_n || ((m_mode[k] != 1) && start)) begin
                m_mode[k] = (!reset_n) ? 0 : 1;
                m_n[k] = 0; m_errs[k] = 0; m_ff[k] = -1;
                m_got[k] = '0; m_exp[k] = '0; m_pass[k] = 1'b0;
            end else if (m_mode[k] == 1 && valid) begin
                if (err_in != 8'h00) begin
                    if (m_ff[k] < 0) begin
                        m_ff[k] = m_n[k];
                        m_got[k] = result_alu;
                        m_exp[k] = res_exp;
                    end
                    m_errs[k]++;
                end
                m_n[k]++;
                if (m_n[k] == NV[k]) begin
                    m_mode[k] = 2;
                    m_pass[k] = (m_errs[k] == 0);
                end
            end
        end
    end

    function automatic int sat(input int k);
        return (m_errs[k] > MAXE[k]) ? MAXE[k] : m_errs[k];
    endfunction

    function automatic int idx(input int k);
        return (m_ff[k] < 0) ? 0 : m_ff[k];
    endfunction

    always @(negedge clock) begin
        if (chk_en) begin
            chk("a.busy", 32'(a_busy), 32'(m_mode[0] == 1));
            chk("a.done", 32'(a_done), 32'(m_mode[0] == 2));
            chk("a.pass", 32'(a_pass), 32'(m_pass[0]));
            chk("a.vec", 32'(a_vec), m_n[0]);
            chk("a.err", 32'(a_err), sat(0));
            chk("a.idx", 32'(a_idx), idx(0));
            chk("a.got", 32'(a_got), 32'(m_got[0]));
            chk("a.exp", 32'(a_exp), 32'(m_exp[0]));
            chk("a.sticky", 32'(a_sticky), 32'(m_ff[0] >= 0));
            chk("b.busy", 32'(b_busy), 32'(m_mode[1] == 1));
            chk("b.done", 32'(b_done), 32'(m_mode[1] == 2));
            chk("b.pass", 32'(b_pass), 32'(m_pass[1]));
            chk("b.vec", 32'(b_vec), m_n[1]);
            chk("b.err", 32'(b_err), sat(1));
            chk("b.idx", 32'(b_idx), idx(1));
            chk("b.got", 32'(b_got), 32'(m_got[1]));
            chk("b.exp", 32'(b_exp), 32'(m_exp[1]));
            chk("b.sticky", 32'(b_sticky), 32'(m_ff[1] >= 0));
        end
    end

    task automatic cyc(input logic s, input logic v, input logic [7:0] e,
                       input logic [14:0] g, input logic [14:0] x);
        @(negedge clock);
        start = s; valid = v; err_in = e; result_alu = g; res_exp = x;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 8'h00, '0, '0);
    endtask

    task automatic sample(input logic [7:0] e);
        cyc(1'b0, 1'b1, e, 15'($urandom), 15'($urandom));
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_n[k] = 0; m_errs[k] = 0; m_ff[k] = -1;
            m_got[k] = '0; m_exp[k] = '0; m_pass[k] = 1'b0;
        end
        reset_n = 1'b0;
        idle(); idle();
        reset_n = 1'b1;
        idle();
        chk("rst.busy", 32'(a_busy), 0);
        chk("rst.done", 32'(a_done), 0);
        chk("rst.vec", 32'(a_vec), 0);

        // Clean run.
        cyc(1'b1, 1'b0, 8'h00, '0, '0);
        for (int i = 0; i < 16; i++) sample(8'h00);
        idle();
        chk("t1.done", 32'(a_done), 1);
        chk("t1.pass", 32'(a_pass), 1);
        chk("t1.vec", 32'(a_vec), 16);
        chk("t1.err", 32'(a_err), 0);

        // Errors at samples 3 and 9.
        cyc(1'b1, 1'b0, 8'h00, '0, '0);
        for (int i = 0; i < 16; i++) begin
            if (i == 3) cyc(1'b0, 1'b1, 8'hFF, 15'h2ABC, 15'h4ABC);
            else if (i == 9) sample(8'hFF);
            else sample(8'h00);
        end
        idle();
        chk("t2.err", 32'(a_err), 2);
        chk("t2.idx", 32'(a_idx), 3);
        chk("t2.got", 32'(a_got), 32'h2ABC);
        chk("t2.exp", 32'(a_exp), 32'h4ABC);
        chk("t2.pass", 32'(a_pass), 0);
        chk("t2.sticky", 32'(a_sticky), 1);

        // Reset mid-run after sample 7, with one error.
        cyc(1'b1, 1'b0, 8'h00, '0, '0);
        for (int i = 0; i < 8; i++) sample((i == 2) ? 8'h0F : 8'h00);
        reset_n = 1'b0;
        idle();
        reset_n = 1'b1;
        idle();
        chk("t5.busy", 32'(a_busy), 0);
        chk("t5.vec", 32'(a_vec), 0);
        chk("t5.sticky", 32'(a_sticky), 0);

        // valid pulses in IDLE, then toggling valid through a clean run.
        for (int i = 0; i < 3; i++) begin sample(8'hFF); idle(); end
        chk("idle.vec", 32'(a_vec), 0);
        cyc(1'b1, 1'b0, 8'h00, '0, '0);
        for (int i = 0; i < 16; i++) begin sample(8'h00); idle(); end
        chk("t3.done", 32'(a_done), 1);
        chk("t3.pass", 32'(a_pass), 1);

        // start mid-run ignored; error only on final sample.
        cyc(1'b1, 1'b0, 8'h00, '0, '0);
        for (int i = 0; i < 16; i++)
            cyc(i == 5, 1'b1, (i == 15) ? 8'h01 : 8'h00,
                15'($urandom), 15'($urandom));
        idle();
        chk("t6.pass", 32'(a_pass), 0);
        chk("t6.err", 32'(a_err), 1);
        chk("t6.idx", 32'(a_idx), 15);
        cyc(1'b1, 1'b0, 8'h00, '0, '0);
        idle();
        chk("t6.restart.done", 32'(a_done), 0);
        chk("t6.restart.vec", 32'(a_vec), 0);

        // Every sample erroring: 4-bit instance saturates.
        for (int i = 0; i < 16; i++) sample(8'($urandom_range(1, 255)));
        idle();
        chk("t4.b_err", 32'(b_err), 32'hF);
        chk("t4.a_err", 32'(a_err), 16);
        for (int i = 0; i < 4; i++) sample(8'hFF);
        chk("t4.b_hold", 32'(b_err), 32'hF);

        // Random soak.
        for (int i = 0; i < 2000; i++) begin
            reset_n = ($urandom_range(0, 199) != 0);
            cyc($urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0,
                ($urandom_range(0, 9) < 7) ? 8'h00 : 8'($urandom),
                15'($urandom), 15'($urandom));
        end
        reset_n = 1'b1;
        idle(); idle();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
